// File: rtl/timer.sv
// Timer block: free-running 16-bit divider (DIV), TIMA counter with TMA
// reload, TAC control, and a one-clock interrupt pulse on reload.
//
// CPU bus protocol: a write is a single-cycle strobe; the register selected by
// addr takes data_w on the posedge where do_write=1 and addr is in range.
// There is no back-pressure, so every strobe is accepted on that edge.
// Reads are combinational from addr with no strobe.
module timer #(
    parameter logic [15:0] BASE = 16'hFF04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  data_w,
    output logic [7:0]  data_r,
    input  logic        do_write,
    output logic        data_active,
    output logic        timer_irq,
    output logic [2:0]  dbg_reload_state
);

    // Reload sequencer: three wait clocks after overflow, then the load clock.
    typedef enum logic [2:0] {
        RL_IDLE  = 3'd0,
        RL_WAIT1 = 3'd1,
        RL_WAIT2 = 3'd2,
        RL_WAIT3 = 3'd3,
        RL_LOAD  = 3'd4
    } rl_state_t;

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_q, tick_d;
    logic        irq_q, irq_d;
    rl_state_t   rl_q, rl_d;

    logic [15:0] offset;
    logic        wr_div, wr_tima, wr_tma, wr_tac;
    logic        sel_bit, tick, inc;

    // Address decode; the wrapping subtraction keeps the range check correct
    // even when BASE sits near the top of the address map.
    always_comb begin
        offset      = addr - BASE;
        data_active = (offset < 16'd4);
        wr_div      = do_write && data_active && (offset[1:0] == 2'd0);
        wr_tima     = do_write && data_active && (offset[1:0] == 2'd1);
        wr_tma      = do_write && data_active && (offset[1:0] == 2'd2);
        wr_tac      = do_write && data_active && (offset[1:0] == 2'd3);
    end

    // Tick source: selected divider bit gated by the enable; TIMA counts on its falling edge.
    always_comb begin
        sel_bit = 1'b0;
        case (tac_q[1:0])
            2'b00:   sel_bit = div_q[9];
            2'b01:   sel_bit = div_q[3];
            2'b10:   sel_bit = div_q[5];
            default: sel_bit = div_q[7];
        endcase
        tick = tac_q[2] & sel_bit;
        inc  = tick_q & ~tick;
    end

    // Next-state for divider, TMA, TAC and the tick history.
    always_comb begin
        div_d  = wr_div ? 16'h0000 : div_q + 16'd1;
        tma_d  = wr_tma ? data_w : tma_q;
        tac_d  = wr_tac ? data_w[2:0] : tac_q;
        tick_d = tick;
    end

    // TIMA next-state and reload sequencing: the load clock ignores TIMA writes
    // and takes the TMA value being written on that same clock.
    always_comb begin
        rl_d = rl_q;
        case (rl_q)
            RL_WAIT1: rl_d = RL_WAIT2;
            RL_WAIT2: rl_d = RL_WAIT3;
            RL_WAIT3: rl_d = RL_LOAD;
            RL_LOAD:  rl_d = RL_IDLE;
            default:  rl_d = RL_IDLE;
        endcase
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (rl_q == RL_LOAD) begin
            tima_d = tma_d;
            irq_d  = 1'b1;
        end else if (wr_tima) begin
            // A CPU write beats an increment and cancels any pending reload.
            tima_d = data_w;
            rl_d   = RL_IDLE;
        end else if (inc) begin
            if (tima_q == 8'hFF) begin
                tima_d = 8'h00;
                rl_d   = RL_WAIT1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 16'h0000;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
            rl_q   <= RL_IDLE;
        end else begin
            div_q  <= div_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            tick_q <= tick_d;
            irq_q  <= irq_d;
            rl_q   <= rl_d;
        end
    end

    // Read mux; unmapped addresses read as all ones.
    always_comb begin
        data_r = 8'hFF;
        if (data_active) begin
            case (offset[1:0])
                2'd0:    data_r = div_q[15:8];
                2'd1:    data_r = tima_q;
                2'd2:    data_r = tma_q;
                default: data_r = {5'b11111, tac_q};
            endcase
        end
    end

    assign timer_irq        = irq_q;
    assign dbg_reload_state = rl_q;

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have parameter BASE, default 'hFF04, meaning the address of DIV; TIMA, TMA and TAC follow at BASE+1..BASE+3.
REQ-002 SHALL have port clk  input  1  system clock, one T-cycle (4.194304 MHz); all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port addr  input  16  CPU bus address.
REQ-005 SHALL have port data_w  input  8  CPU write data.
REQ-006 SHALL have port data_r  output  8  read data, combinational from addr.
REQ-007 SHALL have port do_write  input  1  CPU write strobe, sampled on posedge clk.
REQ-008 SHALL have port data_active  output  1  high combinationally when addr is within BASE..BASE+3.
REQ-009 SHALL have port timer_irq  output  1  one-clk interrupt request pulse to the interrupt logic (IF bit 2).

Function
REQ-010 SHALL hold a 16-bit free-running divider that increments by 1 every clk and wraps FFFF->0000.
REQ-011 SHALL read DIV as divider[15:8]; any write to DIV SHALL set the divider to 0000 on that edge, taking priority over the increment.
REQ-012 SHALL read TIMA and TMA as stored; writes SHALL store data_w.
REQ-013 SHALL store TAC[2:0] from data_w[2:0] and read TAC as {5'b11111, TAC[2:0]}.
REQ-014 SHALL drive data_r = 8'hFF when data_active is low.
REQ-015 SHALL form tick = TAC[2] AND divider[sel], with sel = 9/3/5/7 for TAC[1:0] = 00/01/10/11.
REQ-016 SHALL register tick each clk as tick_q; TIMA SHALL increment on the edge where tick_q=1 and tick=0.
REQ-017 SHALL increment TIMA on any falling edge of tick, including one caused by a DIV write, a TAC disable or a TAC select change.
REQ-018 SHALL let a CPU write to TIMA win over a simultaneous increment.
REQ-019 On an increment from FF, TIMA SHALL become 00 and a reload counter SHALL start.
REQ-020 Exactly 4 clk after the overflow edge, TIMA SHALL load TMA and timer_irq SHALL be 1 for that single clk.
REQ-021 A TIMA write in any of the 3 clks after the overflow edge SHALL cancel the pending reload and the irq.
REQ-022 A TIMA write on the reload clk SHALL be ignored; TMA SHALL be loaded.
REQ-023 A TMA write on the reload clk SHALL store the new TMA, and TIMA SHALL load that new value.
REQ-024 An increment event during the 3-clk delay SHALL increment the 00 value; the reload still overwrites it.
REQ-025 timer_irq SHALL be registered, never high for two consecutive clks, and low in all other cycles.

Reset
REQ-026 While reset=1, the following SHALL be cleared on each edge: divider=0000, TIMA=00, TMA=00, TAC=000, tick_q=0, reload counter idle, timer_irq=0.
REQ-027 SHALL abort any in-flight reload and drop its irq when reset is asserted mid-delay.
REQ-028 SHALL return data_r to the reset register values while reset is high.

Verification
REQ-029 Reset, TAC=05, TIMA=00 -> TIMA=01 after 16 clk and 10 after 256 clk; DIV=01 at clk 256.
REQ-030 TMA=80, TIMA=FF, TAC=05 -> on next tick fall TIMA=00 for 4 clk, then TIMA=80 with timer_irq=1 for exactly 1 clk.
REQ-031 Overflow followed by a write TIMA=33 at clk +2 -> TIMA stays 33 and timer_irq never asserts.
REQ-032 TAC=05 with divider[3]=1, then a write to DIV -> divider=0000 and TIMA increments by 1; repeat with TAC enabled=0 -> no increment.
REQ-033 Overflow with a write TMA=C0 on the reload clk -> TIMA=C0 and timer_irq=1; a write TIMA=11 on the reload clk is ignored (TIMA=TMA).
REQ-034 Read sweep FF03..FF08 after reset -> data_active low/high/high/high/high/low; reads return FF,00,00,00,F8,FF.
